// File: rtl/dft_seq_engine.sv
// Sequential N-point complex DFT: load N samples, run one MAC per (bin, sample)
// pair against a cos/sin ROM, then stream the N bins out with valid/ready.
module dft_seq_engine #(
  parameter int unsigned N  = 16,
  parameter int unsigned W  = 16,
  parameter int unsigned TW = 16,
  localparam int unsigned LOGN = $clog2(N),
  localparam int unsigned AW   = W + TW + LOGN + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_re,
  input  logic signed [W-1:0]  in_im,
  input  logic                 inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_re,
  output logic signed [AW-1:0] out_im,
  output logic [LOGN-1:0]      out_idx,
  output logic                 busy,
  output logic                 done
);

  localparam real Pi = 3.14159265358979323846;
  localparam real Scale = 2.0 ** (TW - 1);
  localparam int MaxTw = (1 << (TW - 1)) - 1;
  localparam logic [LOGN-1:0] Last = LOGN'(N - 1);

  // Round half away from zero, then clip to the symmetric Q1.(TW-1) range.
  function automatic int rom_val(input real v);
    real s;
    int  r;
    s = v * Scale;
    r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    if (r > MaxTw) r = MaxTw;
    if (r < -MaxTw) r = -MaxTw;
    return r;
  endfunction

  logic signed [TW-1:0] cos_rom [N];
  logic signed [TW-1:0] sin_rom [N];

  for (genvar m = 0; m < N; m++) begin : g_rom
    localparam int CosV = rom_val($cos(2.0 * Pi * real'(m) / real'(N)));
    localparam int SinV = rom_val($sin(2.0 * Pi * real'(m) / real'(N)));
    assign cos_rom[m] = TW'(CosV);
    assign sin_rom[m] = TW'(SinV);
  end

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StOutput} state_e;

  state_e                state_q, state_d;
  logic [LOGN-1:0]       cnt_q, k_q, j_q, oidx_q;
  logic                  wb_q, inv_q, done_q;
  logic signed [AW-1:0]  acc_re_q, acc_im_q;

  logic signed [W-1:0]   x_re [N];
  logic signed [W-1:0]   x_im [N];
  logic signed [AW-1:0]  r_re [N];
  logic signed [AW-1:0]  r_im [N];

  logic                  in_xfer;
  logic [LOGN-1:0]       tw_idx;
  logic signed [AW-1:0]  xr_e, xi_e, c_e, s_e, mac_re, mac_im;

  assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state_q == StOutput);
  assign out_idx   = oidx_q;
  assign out_re    = out_valid ? r_re[oidx_q] : '0;
  assign out_im    = out_valid ? r_im[oidx_q] : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // LOGN-bit product wraps naturally, giving (k*j) mod N.
  assign tw_idx = k_q * j_q;
  assign xr_e   = AW'(x_re[j_q]);
  assign xi_e   = AW'(x_im[j_q]);
  assign c_e    = AW'(cos_rom[tw_idx]);
  assign s_e    = inv_q ? -AW'(sin_rom[tw_idx]) : AW'(sin_rom[tw_idx]);
  assign mac_re = xr_e * c_e + xi_e * s_e;
  assign mac_im = xi_e * c_e - xr_e * s_e;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_xfer) state_d = StLoad;
      StLoad:    if (in_xfer && cnt_q == Last) state_d = StCompute;
      StCompute: if (wb_q && k_q == Last) state_d = StOutput;
      StOutput:  if (out_ready && oidx_q == Last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_q      <= '0;
      j_q      <= '0;
      oidx_q   <= '0;
      wb_q     <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_xfer) begin
            inv_q <= inv;
            cnt_q <= LOGN'(1);
          end
        end
        StLoad: begin
          if (in_xfer) cnt_q <= cnt_q + 1'b1;
        end
        StCompute: begin
          if (wb_q) begin
            wb_q <= 1'b0;
            k_q  <= k_q + 1'b1;
          end else begin
            acc_re_q <= ((j_q == '0) ? '0 : acc_re_q) + mac_re;
            acc_im_q <= ((j_q == '0) ? '0 : acc_im_q) + mac_im;
            j_q      <= j_q + 1'b1;
            if (j_q == Last) wb_q <= 1'b1;
          end
        end
        StOutput: begin
          if (out_ready) begin
            oidx_q <= oidx_q + 1'b1;
            if (oidx_q == Last) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers carry no reset; a new frame overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      x_re[cnt_q] <= in_re;
      x_im[cnt_q] <= in_im;
    end
    if (state_q == StCompute && wb_q) begin
      r_re[k_q] <= acc_re_q;
      r_im[k_q] <= acc_im_q;
    end
  end

endmodule

// File: tb/tb_dft_seq_engine.sv
// Self-checking bench for dft_seq_engine (N=8): an integer DFT model fills a
// scoreboard per frame, and each accepted output bin is popped and compared.
module tb_dft_seq_engine;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int TW   = 16;
  localparam int LOGN = 3;
  localparam int AW   = W + TW + LOGN + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [W-1:0]  in_re = '0;
  logic signed [W-1:0]  in_im = '0;
  logic                 inv = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [AW-1:0] out_re;
  logic signed [AW-1:0] out_im;
  logic [LOGN-1:0]      out_idx;
  logic                 busy;
  logic                 done;

  dft_seq_engine #(.N(N), .W(W), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .inv       (inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    longint re;
    longint im;
  } exp_t;

  exp_t   sb[$];
  int     xre[N], xim[N];
  longint got_re[N], got_im[N];
  longint fwd_re[N], fwd_im[N];
  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int twid(input int m, input bit sine);
    real a, v;
    int  r;
    a = 2.0 * 3.141592653589793 * real'(m) / real'(N);
    v = (sine ? $sin(a) : $cos(a)) * 32768.0;
    r = int'(v);
    if (r > 32767) r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  task automatic push_expected(input bit iv);
    for (int k = 0; k < N; k++) begin
      longint ar = 0, ai = 0;
      for (int j = 0; j < N; j++) begin
        int c = twid((k * j) % N, 1'b0);
        int s = twid((k * j) % N, 1'b1);
        if (iv) s = -s;
        ar += longint'(xre[j]) * c + longint'(xim[j]) * s;
        ai += longint'(xim[j]) * c - longint'(xre[j]) * s;
      end
      sb.push_back('{idx: k, re: ar, im: ai});
    end
  endtask

  // Loads one frame; abort leaves the engine 20 cycles into COMPUTE.
  task automatic send_frame(input bit iv, input bit stall, input bit abort);
    int lat, bad;
    push_expected(iv);
    for (int j = 0; j < N; j++) begin
      if (stall && j == 3) begin
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_re    = W'(xre[j]);
      in_im    = W'(xim[j]);
      inv      = (j == 0) ? iv : ~iv;
      if (j == 0 || j == N - 1) check("in_ready_load", in_ready, 1);
      @(posedge clk);
      #1;
    end
    // Junk on the input side while computing must be ignored.
    in_valid = 1'b1;
    in_re    = 16'sh7abc;
    inv      = ~iv;
    lat = 1;
    bad = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad++;
      if (abort && lat == 20) break;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    inv      = 1'b0;
    check("in_ready_compute", bad, 0);
    if (abort) check("busy_compute", busy, 1);
    else check("latency", lat, 73);
  endtask

  task automatic collect_frame(input bit bp);
    int     n = 0, t = 0, d0;
    bit     held = 1'b0;
    longint hre = 0, him = 0;
    int     hidx = 0;
    exp_t   e;
    d0 = done_cnt;
    while (n < N && t < 3000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_re", out_re, hre);
        check("hold_im", out_im, him);
        check("hold_idx", out_idx, hidx);
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("bin_idx", out_idx, e.idx);
          check("bin_re", out_re, e.re);
          check("bin_im", out_im, e.im);
          got_re[e.idx] = out_re;
          got_im[e.idx] = out_im;
        end
        n++;
      end else if (out_valid) begin
        held = 1'b1;
        hre  = out_re;
        him  = out_im;
        hidx = out_idx;
      end
      @(posedge clk);
      #1;
      t++;
    end
    out_ready = 1'b0;
    check("frame_bins", n, N);
    check("done_pulse", done, 1);
    check("valid_drop", out_valid, 0);
    check("busy_end", busy, 0);
    check("in_ready_end", in_ready, 1);
    @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("done_low", done, 0);
  endtask

  task automatic check_impulse();
    int bad = 0;
    for (int k = 0; k < N; k++)
      if (got_re[k] != 64'sd3276700 || got_im[k] != 0) bad++;
    check("impulse_bins", bad, 0);
  endtask

  initial begin
    int bad;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", out_re, 0);
    check("rst_idx", out_idx, 0);
    #14 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Impulse
    for (int j = 0; j < N; j++) begin xre[j] = 0; xim[j] = 0; end
    xre[0] = 100;
    send_frame(1'b0, 1'b0, 1'b0);
    collect_frame(1'b0);
    check_impulse();

    // Constant input with a mid-load stall
    for (int j = 0; j < N; j++) begin xre[j] = 10; xim[j] = 0; end
    send_frame(1'b0, 1'b1, 1'b0);
    collect_frame(1'b0);
    check("const_x0_re", got_re[0], 2621360);
    check("const_x0_im", got_im[0], 0);
    bad = 0;
    for (int k = 1; k < N; k++)
      if (got_re[k] > 80 || got_re[k] < -80 || got_im[k] > 80 || got_im[k] < -80) bad++;
    check("const_small_bins", bad, 0);

    // Cosine, forward then inverse
    for (int j = 0; j < N; j++) begin
      xre[j] = int'($cos(2.0 * 3.141592653589793 * real'(j) / real'(N)) * 1000.0);
      xim[j] = 0;
    end
    send_frame(1'b0, 1'b0, 1'b0);
    collect_frame(1'b0);
    for (int k = 0; k < N; k++) begin fwd_re[k] = got_re[k]; fwd_im[k] = got_im[k]; end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (k != 1 && k != N - 1)
        if (fwd_re[k] * fwd_re[k] + fwd_im[k] * fwd_im[k] >= fwd_re[1] * fwd_re[1] / 4 ||
            fwd_re[k] * fwd_re[k] + fwd_im[k] * fwd_im[k] >= fwd_re[N-1] * fwd_re[N-1] / 4)
          bad++;
    check("cos_peaks", bad, 0);
    send_frame(1'b1, 1'b0, 1'b0);
    collect_frame(1'b1);
    check("inv_x1_im", got_im[1], -fwd_im[1]);
    check("inv_x7_im", got_im[N-1], -fwd_im[N-1]);

    // Random data under random back-pressure
    for (int j = 0; j < N; j++) begin
      xre[j] = int'($signed(16'($urandom)));
      xim[j] = int'($signed(16'($urandom)));
    end
    send_frame(1'b0, 1'b0, 1'b0);
    collect_frame(1'b1);

    // Reset in the middle of COMPUTE, then a clean impulse frame
    for (int j = 0; j < N; j++) begin xre[j] = 0; xim[j] = 0; end
    xre[0] = 100;
    send_frame(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_re", out_re, 0);
    check("arst_idx", out_idx, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready", in_ready, 1);
    send_frame(1'b0, 1'b0, 1'b0);
    collect_frame(1'b1);
    check_impulse();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
